btn_debounce_step: RTL and testbench
====================================

Name: btn_debounce_step

Overview:
- Conditions a raw BASYS3 push-button into clean level and pulse signals for the single-step CPU clock path.
- Sits between the board pin and the step clock-enable FSM; drives that FSM's `btn` input with `step_pulse`.
- Provides 2-FF synchronisation, counter-based debounce, single-cycle press/release pulses, and optional hold-to-auto-step repeat.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive identical synchronised samples needed to accept a level change (10 ms at 100 MHz); legal range >= 2.
- REPEAT_DELAY, 50000000: cycles from the press pulse to the first auto-repeat step (0.5 s); >= 2.
- REPEAT_PERIOD, 10000000: cycles between later auto-repeat steps (0.1 s); >= 2.
- CNT_W, 26: width of the debounce and repeat counters; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- clk  input  1  system clock (100 MHz board clock).
- rst  input  1  synchronous, active-high reset.
- btn_raw  input  1  asynchronous, bouncy button pin.
- repeat_en  input  1  enables auto-repeat while the button is held (slide switch, treated as quasi-static).
- btn_level  output  1  debounced button level.
- press_pulse  output  1  one-cycle pulse when an accepted press occurs.
- release_pulse  output  1  one-cycle pulse when an accepted release occurs.
- step_pulse  output  1  one-cycle pulse on press, or on each auto-repeat tick.

Behaviour:
- Reset (rst high at a clk edge):
  - sync FFs = 0, state = LOW, all counters = 0, repeat_armed = 0.
  - all outputs = 0.
  - rst has priority over every other event, including mid-debounce and mid-repeat.
- Synchroniser: two flops, btn_raw -> s1 -> btn_s. Only btn_s is used by the FSM.
- All outputs are registered. Pulses are exactly one cycle wide.
- State LOW (btn_level = 0):
  - btn_s = 1 -> RISE with dcnt = 1.
- State RISE (btn_level = 0):
  - btn_s = 0 -> LOW, dcnt = 0. No pulse; this is a bounce reject.
  - btn_s = 1 and dcnt = DEBOUNCE_CYCLES-1 -> HIGH. Assert press_pulse and step_pulse for one cycle, set btn_level = 1, rcnt = 0, repeat_armed = 0.
  - Otherwise dcnt++.
- State HIGH (btn_level = 1):
  - btn_s = 0 -> FALL with dcnt = 1.
  - Repeat logic runs here only.
- State FALL (btn_level = 1):
  - btn_s = 1 -> HIGH, dcnt = 0. No pulse; rcnt and repeat_armed keep their values.
  - btn_s = 0 and dcnt = DEBOUNCE_CYCLES-1 -> LOW. Assert release_pulse, set btn_level = 0, rcnt = 0, repeat_armed = 0.
  - Otherwise dcnt++.
- Latency: btn_raw stable high before clk edge 0 -> press_pulse is high after edge DEBOUNCE_CYCLES+1. Release latency is symmetric.
- Auto-repeat, in HIGH with repeat_en = 1:
  - rcnt++ each cycle.
  - Limit is REPEAT_DELAY-1 when repeat_armed = 0, else REPEAT_PERIOD-1.
  - On reaching the limit: step_pulse for one cycle, rcnt = 0, repeat_armed = 1.
  - Resulting step_pulse timing, with P = press edge: P, P+REPEAT_DELAY, then every REPEAT_PERIOD.
- repeat_en = 0 in HIGH: rcnt = 0 and repeat_armed = 0 every cycle, so re-enabling restarts the full REPEAT_DELAY.
- In FALL: rcnt is held and no repeat ticks occur. A bounce back to HIGH resumes the count.
- Simultaneous events: press_pulse and a repeat tick cannot coincide, because rcnt is cleared on press. release_pulse never coincides with step_pulse.
- Counters saturate in no state. Wrap is impossible given the exit conditions.

Test Plan (DEBOUNCE_CYCLES = 4, REPEAT_DELAY = 10, REPEAT_PERIOD = 5, repeat_en = 0 unless stated):
- Reset: rst high for 2 cycles with btn_raw = 1 -> all outputs 0 during reset. After release, press_pulse appears 6 edges later (first edge after rst deasserted counts as edge 0).
- Clean press: btn_raw 0->1 before edge 0, held high -> press_pulse = step_pulse = 1 for exactly one cycle after edge 5, btn_level = 1 from edge 5 on, no further pulses.
- Bounce reject: btn_raw high 3 cycles, low 1, high 3, low -> no press_pulse and btn_level stays 0. Then hold high 4+ cycles -> exactly one press_pulse.
- Release with bounce: from HIGH, btn_raw low 2 cycles, high 1, low held -> btn_level stays 1 until the 4th consecutive low sample. Exactly one release_pulse and no step_pulse.
- Auto-repeat: repeat_en = 1, button held -> step_pulse at P, P+10, P+15, P+20. Dropping repeat_en at P+12 and raising it at P+14 -> next step at P+24.
- Reset mid-operation: rst asserted during RISE (dcnt = 2) and during HIGH (rcnt = 7) -> outputs 0 on the next edge, state LOW, and a full debounce is required afterwards.

Source files
------------

// File: rtl/btn_debounce_step.sv
// rtl/btn_debounce_step.sv - push-button synchroniser, debouncer and step/auto-repeat pulse generator
// Feeds step_pulse to the single-step clock-enable FSM.
module btn_debounce_step #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000,
  parameter int unsigned CNT_W           = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic repeat_en,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic step_pulse
);

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEL_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_LOW  = 2'd0,
    ST_RISE = 2'd1,
    ST_HIGH = 2'd2,
    ST_FALL = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             s1_q, s1_d;
  logic             btn_s_q, btn_s_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic             armed_q, armed_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             step_q, step_d;
  logic [CNT_W-1:0] rep_limit;

  // First auto-step waits the long delay; later ones use the short period.
  assign rep_limit = armed_q ? PER_LAST : DEL_LAST;

  always_comb begin
    s1_d      = btn_raw;
    btn_s_d   = s1_q;
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    rcnt_d    = rcnt_q;
    armed_d   = armed_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    step_d    = 1'b0;

    case (state_q)
      ST_LOW: begin
        if (btn_s_q) begin
          state_d = ST_RISE;
          dcnt_d  = CNT_ONE;
        end
      end

      ST_RISE: begin
        if (!btn_s_q) begin
          state_d = ST_LOW;
          dcnt_d  = CNT_ZERO;
        end else if (dcnt_q == DB_LAST) begin
          state_d = ST_HIGH;
          dcnt_d  = CNT_ZERO;
          level_d = 1'b1;
          press_d = 1'b1;
          step_d  = 1'b1;
          rcnt_d  = CNT_ZERO;
          armed_d = 1'b0;
        end else begin
          dcnt_d = dcnt_q + CNT_ONE;
        end
      end

      ST_HIGH: begin
        if (!btn_s_q) begin
          state_d = ST_FALL;
          dcnt_d  = CNT_ONE;
        end
        // Disabling repeat forces a full delay when it is switched back on.
        if (!repeat_en) begin
          rcnt_d  = CNT_ZERO;
          armed_d = 1'b0;
        end else if (rcnt_q == rep_limit) begin
          step_d  = 1'b1;
          rcnt_d  = CNT_ZERO;
          armed_d = 1'b1;
        end else begin
          rcnt_d = rcnt_q + CNT_ONE;
        end
      end

      ST_FALL: begin
        // Repeat count is frozen here so a bounce back to HIGH resumes it.
        if (btn_s_q) begin
          state_d = ST_HIGH;
          dcnt_d  = CNT_ZERO;
        end else if (dcnt_q == DB_LAST) begin
          state_d   = ST_LOW;
          dcnt_d    = CNT_ZERO;
          level_d   = 1'b0;
          release_d = 1'b1;
          rcnt_d    = CNT_ZERO;
          armed_d   = 1'b0;
        end else begin
          dcnt_d = dcnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = ST_LOW;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= 1'b0;
      btn_s_q   <= 1'b0;
      state_q   <= ST_LOW;
      dcnt_q    <= CNT_ZERO;
      rcnt_q    <= CNT_ZERO;
      armed_q   <= 1'b0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      btn_s_q   <= btn_s_d;
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
      rcnt_q    <= rcnt_d;
      armed_q   <= armed_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      step_q    <= step_d;
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign step_pulse    = step_q;

endmodule

// File: tb/tb_btn_debounce_step.sv
// tb/tb_btn_debounce_step.sv - directed and random checks of btn_debounce_step against a run-length model
module tb_btn_debounce_step;

  localparam int D   = 4;
  localparam int DEL = 10;
  localparam int PER = 5;

  logic clk = 1'b0;
  logic rst, btn_raw, repeat_en;
  logic btn_level, press_pulse, release_pulse, step_pulse;

  int n_assert = 0;
  int n_fail   = 0;
  int n_press, n_rel, n_step;

  // Reference model: raw history, run of samples disagreeing with the level,
  // and cycles spent in a stable-high state since the last step.
  logic h0 = 0, h1 = 0;
  logic m_level = 0, m_press = 0, m_rel = 0, m_step = 0, m_armed = 0;
  int   m_run = 0, m_ctr = 0;

  btn_debounce_step #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(DEL),
    .REPEAT_PERIOD(PER),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_raw(btn_raw),
    .repeat_en(repeat_en),
    .btn_level(btn_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .step_pulse(step_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic raw, input logic ren, input logic r);
    logic bs;
    logic was_high;
    m_press = 0; m_rel = 0; m_step = 0;
    if (r) begin
      h0 = 0; h1 = 0; m_level = 0; m_run = 0; m_ctr = 0; m_armed = 0;
      return;
    end
    bs = h1;
    h1 = h0;
    h0 = raw;
    was_high = m_level && (m_run == 0);
    if (bs != m_level) begin
      m_run++;
      if (m_run == D) begin
        m_level = ~m_level;
        m_run   = 0;
        m_ctr   = 0;
        m_armed = 0;
        if (m_level) begin m_press = 1; m_step = 1; end
        else m_rel = 1;
      end
    end else begin
      m_run = 0;
    end
    if (was_high) begin
      if (!ren) begin
        m_ctr = 0; m_armed = 0;
      end else if (m_ctr == (m_armed ? PER : DEL) - 1) begin
        m_step = 1; m_ctr = 0; m_armed = 1;
      end else begin
        m_ctr++;
      end
    end
  endtask

  task automatic tick(input logic raw, input logic ren, input logic r);
    btn_raw = raw; repeat_en = ren; rst = r;
    @(posedge clk);
    model_edge(raw, ren, r);
    #1;
    chk("btn_level", btn_level, m_level);
    chk("press_pulse", press_pulse, m_press);
    chk("release_pulse", release_pulse, m_rel);
    chk("step_pulse", step_pulse, m_step);
    n_press += int'(press_pulse);
    n_rel   += int'(release_pulse);
    n_step  += int'(step_pulse);
  endtask

  initial begin
    logic raw_r, ren_r;
    int   run_left;
    rst = 1; btn_raw = 1; repeat_en = 0;

    // reset with button already held
    tick(1, 0, 1);
    chk("rst_outputs", {btn_level, press_pulse, release_pulse, step_pulse}, 0);
    tick(1, 0, 1);
    chk("rst_outputs2", {btn_level, press_pulse, release_pulse, step_pulse}, 0);
    for (int i = 0; i < 8; i++) begin
      tick(1, 0, 0);
      chk("rst_press_timing", press_pulse, (i == 5));
    end

    for (int i = 0; i < 10; i++) tick(0, 0, 0);
    chk("released_level", btn_level, 0);

    // clean press
    n_press = 0; n_step = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1, 0, 0);
      chk("clean_press", press_pulse, (i == 5));
      chk("clean_step", step_pulse, (i == 5));
      chk("clean_level", btn_level, (i >= 5));
    end
    chk("clean_press_count", n_press, 1);

    // release with bounce: low 2, high 1, low held
    n_rel = 0; n_step = 0;
    tick(0, 0, 0); tick(0, 0, 0); tick(1, 0, 0);
    for (int i = 0; i < 12; i++) tick(0, 0, 0);
    chk("bounce_release_count", n_rel, 1);
    chk("bounce_release_steps", n_step, 0);
    chk("bounce_release_level", btn_level, 0);

    // bounce reject on press, then a real hold
    n_press = 0;
    for (int i = 0; i < 3; i++) tick(1, 0, 0);
    tick(0, 0, 0);
    for (int i = 0; i < 3; i++) tick(1, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0);
    chk("reject_press_count", n_press, 0);
    chk("reject_level", btn_level, 0);
    for (int i = 0; i < 10; i++) tick(1, 0, 0);
    chk("hold_press_count", n_press, 1);
    for (int i = 0; i < 10; i++) tick(0, 0, 0);

    // auto-repeat: steps at P, P+10, P+15, P+20 with P = 5
    for (int i = 0; i < 28; i++) begin
      tick(1, 1, 0);
      chk("repeat_step", step_pulse, (i == 5 || i == 15 || i == 20 || i == 25));
    end
    for (int i = 0; i < 10; i++) tick(0, 1, 0);

    // repeat_en low for edges P+13..P+14 restarts the full delay: next at P+24
    for (int i = 0; i < 32; i++) begin
      tick(1, !(i == 18 || i == 19), 0);
      chk("repeat_gap_step", step_pulse, (i == 5 || i == 15 || i == 29));
    end
    for (int i = 0; i < 10; i++) tick(0, 0, 0);

    // reset in RISE with dcnt = 2
    for (int i = 0; i < 4; i++) tick(1, 0, 0);
    tick(1, 0, 1);
    chk("rst_rise_outputs", {btn_level, press_pulse, step_pulse}, 0);
    for (int i = 0; i < 8; i++) begin
      tick(1, 0, 0);
      chk("rst_rise_redebounce", press_pulse, (i == 5));
    end

    // reset in HIGH with rcnt = 7
    for (int i = 0; i < 7; i++) tick(1, 1, 0);
    tick(1, 1, 1);
    chk("rst_high_outputs", {btn_level, press_pulse, step_pulse}, 0);
    for (int i = 0; i < 8; i++) begin
      tick(1, 0, 0);
      chk("rst_high_level", btn_level, (i >= 5));
    end

    // random bouncy stimulus against the model
    raw_r = 0; ren_r = 1; run_left = 0;
    for (int i = 0; i < 1500; i++) begin
      if (run_left == 0) begin
        raw_r = ~raw_r;
        run_left = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 40) : $urandom_range(1, 6);
      end
      run_left--;
      if ($urandom_range(0, 60) == 0) ren_r = ~ren_r;
      tick(raw_r, ren_r, ($urandom_range(0, 400) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
